mips_main_control_fsm: RTL and testbench
========================================

Name: mips_main_control_fsm

Overview:
- Multi-cycle main control unit for the MIPS core.
- Sequences instruction execution through fetch, decode, execute, memory and writeback states, one state per clock.
- Drives the datapath mux selects, memory and register strobes, the unconditional PC enable, and the five per-branch-type PC write qualifiers.
- The PC-load combining logic ANDs those qualifiers with the ALU zero/negative flags.
- Memory accesses stall on a ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEM_READ/MEM_WRITE wait for MEM_RDY; 0 = MEM_RDY ignored and treated as 1.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- OPCODE  input  6  IR[31:26]; stable from DECODE onward
- MEM_RDY  input  1  memory completes the current access this cycle
- PC_EN  output  1  unconditional PC write
- PCWrite_BEQ, PCWrite_BNE, PCWrite_BLEZ, PCWrite_BGTZ, PCWrite_BLTZ  output  1 each  branch-qualified PC write
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  writeback data select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded, 11 = opcode-decoded immediate op
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ILLEGAL_OP  output  1  one-cycle pulse on an unsupported opcode
- STATE  output  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Codes 12-15 are unreachable; if entered, they go to FETCH on the next clock with all outputs 0.
- Reset: RST high forces the state to FETCH asynchronously and forces every output to 0, including STATE. The first FETCH cycle starts at the first rising edge after RST falls.
- Reset mid-instruction abandons it; no partial strobes are issued after RST.
- Outputs default to 0 unless listed below. They are decoded from the state; the Mealy terms are noted.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PC_EN=MEM_RDY (Mealy).
  - Stays in FETCH while MEM_RDY=0; goes to DECODE when MEM_RDY=1.
  - The PC increments exactly once per fetch.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by OPCODE:
    - 000000 -> R_EXEC
    - 100011 / 101011 -> MEM_ADDR
    - 000100 / 000101 / 000110 / 000111 / 000001 -> BRANCH
    - 000010 -> JUMP
    - 001000 / 001100 / 001101 / 001010 -> I_EXEC
    - any other opcode -> FETCH with ILLEGAL_OP=1 for this cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1. Holds until MEM_RDY=1, then goes to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1. Goes to FETCH.
- MEM_WRITE:
  - MemWrite=1, IorD=1, held for every wait cycle.
  - Goes to FETCH on MEM_RDY=1.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - Exactly one qualifier is high, selected by OPCODE: 000100 -> PCWrite_BEQ, 000101 -> PCWrite_BNE, 000110 -> PCWrite_BLEZ, 000111 -> PCWrite_BGTZ, 000001 -> PCWrite_BLTZ.
  - PC_EN=0. Goes to FETCH.
- JUMP: PCSource=10, PC_EN=1. Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Cycle counts with MEM_RDY tied high:
  - R-type, I-type and SW: 4 cycles.
  - LW: 5 cycles.
  - Branch and jump: 3 cycles.
  - Each MEM_RDY=0 cycle adds one cycle.
- Invariants:
  - MemRead and MemWrite are never both high.
  - PC_EN and any PCWrite_* qualifier are never both high.
  - At most one PCWrite_* qualifier is high in any cycle.

Test Plan:
- RST pulse mid-MEM_READ with MEM_RDY=0 -> all outputs 0 immediately. After release, STATE=0 with MemRead=1; IRWrite=1 and PC_EN=1 once MEM_RDY=1.
- R-type (OPCODE=000000), MEM_RDY=1 -> STATE sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; 4 cycles total.
- LW (100011) with MEM_RDY low for 3 cycles in MEM_READ -> sequence 0,1,2,3,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in state 4.
- SW (101011) with MEM_RDY low 2 cycles -> MemWrite=1 for 3 consecutive cycles in state 5, then FETCH; RegWrite stays 0 throughout.
- Each branch opcode 000100/000101/000110/000111/000001 -> in state 8, only the matching PCWrite_* is 1, PCSource=01, ALUOp=01; PC_EN=0.
- J (000010) -> state 9 with PC_EN=1 and PCSource=10. Opcode 111111 -> ILLEGAL_OP pulses 1 cycle in state 1, then state 0.

Source files
------------

// File: rtl/mips_main_control_fsm.sv
// mips_main_control_fsm
// ---------------------------------------------------------------------------
// Multi-cycle main control unit for the MIPS core. One state per clock walks
// each instruction through fetch, decode, execute, memory and writeback. The
// datapath control word is decoded from the current state. The FETCH strobes
// IRWrite/PC_EN and the DECODE ILLEGAL_OP pulse also depend on the inputs.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   OPCODE[5:0]     IR[31:26], stable from DECODE onward
//   MEM_RDY         memory completes the current access this cycle
//   PC_EN           unconditional PC write
//   PCWrite_*       branch-qualified PC writes (BEQ/BNE/BLEZ/BGTZ/BLTZ)
//   IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]   datapath controls
//   ILLEGAL_OP      one-cycle pulse in DECODE on an unsupported opcode
//   STATE[3:0]      current state encoding, for debug
// ---------------------------------------------------------------------------
module mips_main_control_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OPCODE,
  input  logic       MEM_RDY,
  output logic       PC_EN,
  output logic       PCWrite_BEQ,
  output logic       PCWrite_BNE,
  output logic       PCWrite_BLEZ,
  output logic       PCWrite_BGTZ,
  output logic       PCWrite_BLTZ,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ILLEGAL_OP,
  output logic [3:0] STATE
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_I_EXEC    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [3:0] state_q, state_d;
  // High while RST is asserted and for the remainder of the cycle in which
  // it is released, so the first real FETCH cycle begins on a clean edge.
  logic       in_rst_q;
  logic       rdy;

  assign rdy = (MEM_HANDSHAKE != 0) ? MEM_RDY : 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_rst_q <= 1'b1;
      state_q  <= S_FETCH;
    end else begin
      in_rst_q <= 1'b0;
      state_q  <= in_rst_q ? S_FETCH : state_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    PC_EN        = 1'b0;
    PCWrite_BEQ  = 1'b0;
    PCWrite_BNE  = 1'b0;
    PCWrite_BLEZ = 1'b0;
    PCWrite_BGTZ = 1'b0;
    PCWrite_BLTZ = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    ILLEGAL_OP   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR load and PC+4 commit only on the completing cycle, so the PC
        // advances exactly once however long the fetch stalls.
        IRWrite = rdy;
        PC_EN   = rdy;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OPCODE)
          OP_RTYPE:                                   state_d = S_R_EXEC;
          OP_LW, OP_SW:                               state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ:  state_d = S_BRANCH;
          OP_J:                                       state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:          state_d = S_I_EXEC;
          default: begin
            ILLEGAL_OP = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (OPCODE == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = rdy ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = rdy ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b01;
        PCSource     = 2'b01;
        PCWrite_BEQ  = (OPCODE == OP_BEQ);
        PCWrite_BNE  = (OPCODE == OP_BNE);
        PCWrite_BLEZ = (OPCODE == OP_BLEZ);
        PCWrite_BGTZ = (OPCODE == OP_BGTZ);
        PCWrite_BLTZ = (OPCODE == OP_BLTZ);
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PC_EN    = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      default: begin
        // Unreachable codes 12-15: outputs stay 0, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    // Reset blanks the whole control word, including Mealy terms.
    if (in_rst_q) begin
      PC_EN        = 1'b0;
      PCWrite_BEQ  = 1'b0;
      PCWrite_BNE  = 1'b0;
      PCWrite_BLEZ = 1'b0;
      PCWrite_BGTZ = 1'b0;
      PCWrite_BLTZ = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSource     = 2'b00;
      ILLEGAL_OP   = 1'b0;
    end
  end

  assign STATE = in_rst_q ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Randomized testbench for mips_main_control_fsm. Each instruction is turned
// into its expected per-cycle list of states (with MEM_RDY stalls), and every
// cycle the control word is compared against the table for that state.
module tb_mips_main_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] OPCODE;
  logic       MEM_RDY;
  logic       PC_EN, PCWrite_BEQ, PCWrite_BNE, PCWrite_BLEZ, PCWrite_BGTZ, PCWrite_BLTZ;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       ILLEGAL_OP;
  logic [3:0] STATE;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  mips_main_control_fsm #(.MEM_HANDSHAKE(1)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MEM_RDY(MEM_RDY),
    .PC_EN(PC_EN), .PCWrite_BEQ(PCWrite_BEQ), .PCWrite_BNE(PCWrite_BNE),
    .PCWrite_BLEZ(PCWrite_BLEZ), .PCWrite_BGTZ(PCWrite_BGTZ), .PCWrite_BLTZ(PCWrite_BLTZ),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .ILLEGAL_OP(ILLEGAL_OP), .STATE(STATE)
  );

  logic [20:0] got_w;
  logic [4:0]  qual_w;
  assign qual_w = {PCWrite_BEQ, PCWrite_BNE, PCWrite_BLEZ, PCWrite_BGTZ, PCWrite_BLTZ};
  assign got_w  = {PC_EN, qual_w, IorD, MemRead, MemWrite, IRWrite, RegDst,
                   MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ILLEGAL_OP};

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  localparam logic [5:0] LEGAL [14] = '{6'b000000, 6'b100011, 6'b101011,
    6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b000010,
    6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_branch(input logic [5:0] op);
    return op == 6'b000100 || op == 6'b000101 || op == 6'b000110 ||
           op == 6'b000111 || op == 6'b000001;
  endfunction

  function automatic bit is_itype(input logic [5:0] op);
    return op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000010 || is_branch(op) || is_itype(op);
  endfunction

  // Control word required in a given state, straight from the state table.
  function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
    logic pc_en, beq, bne, blez, bgtz, bltz, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
    logic [1:0] srcb, aluop, pcs;
    {pc_en, beq, bne, blez, bgtz, bltz, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill} = '0;
    srcb = 2'b00; aluop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pc_en = rdy; end
      1:  begin srcb = 2'b11; ill = !is_legal(op); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin
            srca = 1; aluop = 2'b01; pcs = 2'b01;
            beq = (op == 6'b000100); bne = (op == 6'b000101); blez = (op == 6'b000110);
            bgtz = (op == 6'b000111); bltz = (op == 6'b000001);
          end
      9:  begin pcs = 2'b10; pc_en = 1; end
      10: begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pc_en, beq, bne, blez, bgtz, bltz, iord, mrd, mwr, irw, rdst, m2r, rw,
            srca, srcb, aluop, pcs, ill};
  endfunction

  task automatic check_cycle(input logic [3:0] st, input logic rdy);
    check_eq("state", {28'd0, STATE}, {28'd0, st});
    check_eq("ctrl", {11'd0, got_w}, {11'd0, exp_ctrl(int'(st), OPCODE, rdy)});
    check_eq("inv_rd_wr", {31'd0, MemRead & MemWrite}, 32'd0);
    check_eq("inv_pcen_qual", {31'd0, PC_EN & (|qual_w)}, 32'd0);
    check_eq("inv_qual_onehot", {31'd0, ($countones(qual_w) > 1)}, 32'd0);
  endtask

  // Expand one instruction into its cycle list; fw/mw = stall cycles in
  // fetch / memory access. limit >= 0 stops after that many cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int limit);
    step_t q[$];
    for (int i = 0; i < fw; i++) q.push_back('{4'd0, 1'b0});
    q.push_back('{4'd0, 1'b1});
    q.push_back('{4'd1, 1'($urandom)});
    if (op == 6'b000000) begin
      q.push_back('{4'd6, 1'($urandom)}); q.push_back('{4'd7, 1'($urandom)});
    end else if (op == 6'b100011) begin
      q.push_back('{4'd2, 1'($urandom)});
      for (int i = 0; i < mw; i++) q.push_back('{4'd3, 1'b0});
      q.push_back('{4'd3, 1'b1});
      q.push_back('{4'd4, 1'($urandom)});
    end else if (op == 6'b101011) begin
      q.push_back('{4'd2, 1'($urandom)});
      for (int i = 0; i < mw; i++) q.push_back('{4'd5, 1'b0});
      q.push_back('{4'd5, 1'b1});
    end else if (is_branch(op)) begin
      q.push_back('{4'd8, 1'($urandom)});
    end else if (op == 6'b000010) begin
      q.push_back('{4'd9, 1'($urandom)});
    end else if (is_itype(op)) begin
      q.push_back('{4'd10, 1'($urandom)}); q.push_back('{4'd11, 1'($urandom)});
    end
    for (int i = 0; i < q.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      @(negedge CLK);
      MEM_RDY = q[i].rdy;
      OPCODE  = (q[i].st == 4'd0) ? 6'($urandom) : op;
      #1;
      check_cycle(q[i].st, q[i].rdy);
    end
  endtask

  task automatic check_blank(input string tag);
    check_eq(tag, {11'd0, got_w}, 32'd0);
    check_eq({tag, "_state"}, {28'd0, STATE}, 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    RST = 1'b1; MEM_RDY = 1'b1; OPCODE = 6'd0;
    repeat (2) @(negedge CLK);
    #1 check_blank("reset");
    @(negedge CLK);
    MEM_RDY = 1'b0; RST = 1'b0;
    #1 check_blank("reset_release");

    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 1, 3, -1);
    run_instr(6'b101011, 0, 2, -1);
    for (int i = 3; i < 8; i++) run_instr(LEGAL[i], 0, 0, -1);
    run_instr(6'b000010, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);

    // Abort an LW while MEM_READ is stalled.
    run_instr(6'b100011, 0, 5, 5);
    MEM_RDY = 1'b0;
    #2 RST = 1'b1;
    #1 check_blank("rst_mid_read");
    @(negedge CLK);
    RST = 1'b0;
    #1 check_blank("rst_mid_release");
    run_instr(6'b100011, 2, 0, -1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) < 14) op = LEGAL[$urandom_range(0, 13)];
      else begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b111111;
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
